// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU and its sweep sequencer, plus the
// sequencer state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_sweep_settle_cnt.sv
// Loadable down-counter for the ALU settle window; zero flag marks the
// cycle on which the ALU outputs may be sampled.
module alu_sweep_settle_cnt #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(SETTLE_CYCLES - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Sweeps alu_op over 0..OP_COUNT-1 for one latched operand pair and streams
// each ALU response as a valid/ready beat. ALU_SWEEP_CHECKSUM_EN adds a checksum output.
//
// state  | meaning
// IDLE   | waiting for start; ALU drive holds last sweep's values
// SETTLE | opcode applied, counting down the settle window
// HOLD   | result beat presented, waiting for res_ready
// DONE   | one-cycle completion pulse
module alu_sweep_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = ALU_DATA_W,
  parameter int OP_W          = ALU_OP_W,
  parameter int OP_COUNT      = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OP_W-1:0]   res_op,
  output logic [DATA_W-1:0] res_y,
  output logic              res_cout,
  output logic              res_zero
`ifdef ALU_SWEEP_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam logic [OP_W-1:0] LAST_OP = OP_W'(OP_COUNT - 1);

  seq_state_t state, state_next;
  logic cnt_load, cnt_dec, cnt_zero;
  logic accept, sample, advance;
  logic handshake;

  assign handshake = res_valid && res_ready;

  alu_sweep_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    accept     = 1'b0;
    sample     = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          sample     = 1'b1;
          state_next = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          if (alu_op == LAST_OP) begin
            state_next = ST_DONE;
          end else begin
            advance    = 1'b1;
            cnt_load   = 1'b1;
            state_next = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_y     <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);
      if (accept) begin
        alu_a  <= a_in;
        alu_b  <= b_in;
        alu_op <= '0;
      end else if (advance) begin
        alu_op <= alu_op + OP_W'(1);
      end
      if (sample) begin
        res_op    <= alu_op;
        res_y     <= alu_y;
        res_cout  <= alu_cout;
        res_zero  <= alu_zero;
        res_valid <= 1'b1;
      end else if (handshake) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SWEEP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= checksum + 8'({res_op, res_cout, res_y});
    end
  end
`endif

endmodule
